execute_mc: RTL and testbench
=============================

Name: execute_mc

Overview:
- Registered, multi-cycle successor to the single-cycle Execute stage of the LEGv8 datapath.
- Width is parametrised. Handles single-cycle ALU ops plus an iterative shift-add multiplier (MUL) with a valid/ready stall handshake toward decode.
- Results, branch target, store data and zero flag are registered into an EX/MEM-style output stage with a one-cycle valid strobe.
- Sits between register-read/decode and memory/writeback.

Parameters:
- N, 64, datapath width in bits (≥8, multiple of BITS_PER_CYCLE).
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle (1, 2 or 4); S = N/BITS_PER_CYCLE multiply steps.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_E  in  1  operation present on inputs this cycle.
- ready_E  out  1  stage can accept; operation accepted on an edge where valid_E && ready_E && !reset.
- MulOp_E  in  1  1 = MUL, 0 = ALU op.
- AluSrc  in  1  B operand select: 0 = readData2_E, 1 = signImm_E.
- AluControl  in  4  ALU function (ignored when MulOp_E=1).
- BranchSrc_E  in  1  branch target select: 0 = PC_E + (signImm_E<<2), 1 = readData1_E.
- PC_E, signImm_E, readData1_E, readData2_E  in  N  operands.
- valid_M  out  1  one-cycle strobe: registered outputs are new.
- PCBranch_M  out  N  registered branch target.
- aluResult_M  out  N  registered ALU result or low N bits of product.
- writeData_M  out  N  registered readData2_E of the accepted op.
- zero_M  out  1  registered (aluResult_M == 0).

Behaviour:
- Reset (sync, at any time including mid-multiply): state->IDLE, step counter->0, accumulator->0, all _M outputs->0, valid_M->0. Any accept in the reset cycle is discarded.
- States: IDLE, MUL_BUSY. ready_E = (state == IDLE), combinational.
- A = readData1_E; B = AluSrc ? signImm_E : readData2_E.
- ALU encodings:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A−B); 0111 pass B; 1100 NOR.
  - All others give result 0.
  - All arithmetic is modulo 2^N; no flags other than zero.
- ALU op accepted at edge k (IDLE, MulOp_E=0):
  - All _M outputs load at edge k; valid_M = 1 for the cycle after edge k.
  - Stays IDLE, so back-to-back accepts every cycle are allowed.
- MUL accepted at edge k (IDLE, MulOp_E=1):
  - Latch A as multiplicand and B as multiplier. Latch PCBranch and writeData values at accept; they are not re-sampled later.
  - Clear accumulator and counter; go to MUL_BUSY.
- MUL_BUSY: each edge adds (multiplicand × low BITS_PER_CYCLE multiplier bits) to the accumulator. Then the multiplicand shifts left and the multiplier shifts right by BITS_PER_CYCLE; counter increments.
- On the S-th busy edge (edge k+S):
  - _M outputs load the final low-N product; zero_M reflects the product.
  - valid_M pulses for one cycle; state returns to IDLE, so ready_E is high in that same cycle.
- Signed and unsigned operands give identical low-N results; no special sign handling.
- While MUL_BUSY: valid_E and all inputs are ignored. Upstream must hold its op until ready_E.
- valid_M is 0 in every cycle not immediately following a completing edge. _M data holds its last value when valid_M = 0.
- Latency: ALU 1 edge; MUL S+1 edges from accept to valid_M.
- Wrap: PC_E + (signImm_E<<2) truncates to N bits; the shift discards the top 2 bits of signImm_E.
- No downstream backpressure; the consumer must take each valid_M strobe.

Test Plan:
- N=64, BPC=1: valid ALU ADD, A=5, readData2=7, AluSrc=0 -> next cycle valid_M=1, aluResult_M=12, zero_M=0, ready_E stays 1.
- SUB A=B=0x1234 then AND with AluSrc=1, signImm=0xF0, A=0xFF on the next cycle -> aluResult_M 0 (zero_M=1), then 0xF0. Also: invalid code 1111 -> aluResult_M 0, zero_M=1.
- Branch target: PC_E=0x1000, signImm_E=4, BranchSrc=0 -> PCBranch_M=0x1010. BranchSrc=1, readData1=0xDEAD -> 0xDEAD. PC_E=2^64−4, signImm_E=1 -> PCBranch_M=0 (wrap).
- MUL: A=3, B=−2 (0xFFFF_FFFF_FFFF_FFFE) -> ready_E low 64 cycles, valid_M after edge 65, aluResult_M=0xFFFF_FFFF_FFFF_FFFA. An ALU op with valid_E high mid-busy produces no output.
- Reset asserted at busy step 20 -> next cycle IDLE, ready_E=1, valid_M=0, all _M=0. A following ADD 1+1 gives 2 normally.
- N=32, BPC=4: MUL 0xFFFF × 0xFFFF -> valid_M after 9 edges, aluResult_M=0xFFFE0001. Immediately followed by a MUL 0×7 -> aluResult_M=0, zero_M=1.

Source files
------------

// File: rtl/execute_mc_if.sv
// Bundle of decode-side operands/handshake and the registered EX/MEM outputs
// for the multi-cycle execute stage.
interface execute_mc_if #(
  parameter int N = 64
);
  logic         valid_E;
  logic         ready_E;
  logic         MulOp_E;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic         BranchSrc_E;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic         valid_M;
  logic [N-1:0] PCBranch_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;

  // Upstream/downstream side: drives operands, consumes results.
  modport master (
    output valid_E, MulOp_E, AluSrc, AluControl, BranchSrc_E,
           PC_E, signImm_E, readData1_E, readData2_E,
    input  ready_E, valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );

  // Execute stage side.
  modport slave (
    input  valid_E, MulOp_E, AluSrc, AluControl, BranchSrc_E,
           PC_E, signImm_E, readData1_E, readData2_E,
    output ready_E, valid_M, PCBranch_M, aluResult_M, writeData_M, zero_M
  );
endinterface

// File: rtl/execute_mc.sv
// Multi-cycle LEGv8 execute stage: single-cycle ALU ops plus an iterative
// shift-add multiplier, with all results registered into an EX/MEM stage.
module execute_mc #(
  parameter int N              = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  execute_mc_if.slave  bus
);
  localparam int S  = N / BITS_PER_CYCLE;
  localparam int CW = $clog2(S) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(S - 1);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  state_t       state;

  // Multiplier working registers
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic [N-1:0] acc;
  logic [CW-1:0] count;

  // Values captured at MUL accept, published only when the product is ready
  logic [N-1:0] pc_hold;
  logic [N-1:0] wd_hold;

  // Registered EX/MEM outputs
  logic         valid_r;
  logic [N-1:0] pc_r;
  logic [N-1:0] alu_r;
  logic [N-1:0] wd_r;
  logic         zero_r;

  // Combinational datapath
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] alu_out;
  logic [N-1:0] branch_target;
  logic [N-1:0] digit;
  logic [N-1:0] partial;
  logic [N-1:0] acc_next;

  assign bus.ready_E     = (state == IDLE);
  assign bus.valid_M     = valid_r;
  assign bus.PCBranch_M  = pc_r;
  assign bus.aluResult_M = alu_r;
  assign bus.writeData_M = wd_r;
  assign bus.zero_M      = zero_r;

  assign op_a = bus.readData1_E;
  assign op_b = bus.AluSrc ? bus.signImm_E : bus.readData2_E;

  // ALU function decode; unlisted encodings deliberately yield zero
  always_comb begin
    alu_out = '0;
    case (bus.AluControl)
      4'b0000: alu_out = op_a & op_b;
      4'b0001: alu_out = op_a | op_b;
      4'b0010: alu_out = op_a + op_b;
      4'b0110: alu_out = op_a - op_b;
      4'b0111: alu_out = op_b;
      4'b1100: alu_out = ~(op_a | op_b);
      default: alu_out = '0;
    endcase
  end

  // Branch target: register jump or PC-relative word offset (wraps mod 2^N)
  always_comb begin
    branch_target = bus.PC_E + {bus.signImm_E[N-3:0], 2'b00};
    if (bus.BranchSrc_E) begin
      branch_target = bus.readData1_E;
    end
  end

  // One multiply step: add multiplicand times the lowest multiplier digit
  always_comb begin
    digit                     = '0;
    digit[BITS_PER_CYCLE-1:0] = mplier[BITS_PER_CYCLE-1:0];
    partial                   = mcand * digit;
    acc_next                  = acc + partial;
  end

  // Stage control, multiplier iteration and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      pc_hold <= '0;
      wd_hold <= '0;
      valid_r <= 1'b0;
      pc_r    <= '0;
      alu_r   <= '0;
      wd_r    <= '0;
      zero_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_E) begin
            if (bus.MulOp_E) begin
              mcand   <= op_a;
              mplier  <= op_b;
              acc     <= '0;
              count   <= '0;
              pc_hold <= branch_target;
              wd_hold <= bus.readData2_E;
              state   <= MUL_BUSY;
            end else begin
              alu_r   <= alu_out;
              zero_r  <= (alu_out == '0);
              pc_r    <= branch_target;
              wd_r    <= bus.readData2_E;
              valid_r <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          count  <= count + CW'(1);
          if (count == LAST_STEP) begin
            alu_r   <= acc_next;
            zero_r  <= (acc_next == '0);
            pc_r    <= pc_hold;
            wd_r    <= wd_hold;
            valid_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: a 64-bit/1-bit-per-cycle instance and a
// 32-bit/4-bits-per-cycle instance sharing one clock and reset.
module tb_execute_mc;
  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  execute_mc_if #(.N(64)) bus_a ();
  execute_mc_if #(.N(32)) bus_b ();

  execute_mc #(.N(64), .BITS_PER_CYCLE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  execute_mc #(.N(32), .BITS_PER_CYCLE(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic mul, input logic [3:0] ctl, input logic src,
                         input logic bsrc, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] rd1, input logic [63:0] rd2);
    bus_a.valid_E     = 1'b1;
    bus_a.MulOp_E     = mul;
    bus_a.AluControl  = ctl;
    bus_a.AluSrc      = src;
    bus_a.BranchSrc_E = bsrc;
    bus_a.PC_E        = pc;
    bus_a.signImm_E   = imm;
    bus_a.readData1_E = rd1;
    bus_a.readData2_E = rd2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 64'h100, 64'h1, 64'd9, 64'd9);
    tick();
    tick();
    compared++;
    if (bus_a.valid_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus_a.valid_M);
    end
    compared++;
    if (bus_a.ready_E !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b expected 1", bus_a.ready_E);
    end
    compared++;
    if (bus_a.aluResult_M !== 64'd0 || bus_a.PCBranch_M !== 64'd0 ||
        bus_a.writeData_M !== 64'd0 || bus_a.zero_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got alu=%h pc=%h wd=%h z=%b expected all 0",
               bus_a.aluResult_M, bus_a.PCBranch_M, bus_a.writeData_M, bus_a.zero_M);
    end
    compared++;
    if (bus_b.valid_M !== 1'b0 || bus_b.aluResult_M !== 32'd0 || bus_b.ready_E !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_dut32: got v=%b alu=%h rdy=%b expected 0/0/1",
               bus_b.valid_M, bus_b.aluResult_M, bus_b.ready_E);
    end
    bus_a.valid_E = 1'b0;
    reset = 1'b0;
    tick();
    compared++;
    if (bus_a.valid_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_accept_discarded: got %b expected 0", bus_a.valid_M);
    end
  endtask

  task automatic test_alu_add();
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 64'h1000, 64'h4, 64'd5, 64'd7);
    tick();
    bus_a.valid_E = 1'b0;
    compared++;
    if (bus_a.valid_M !== 1'b1 || bus_a.aluResult_M !== 64'd12 || bus_a.zero_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_result: got v=%b alu=%h z=%b expected 1/c/0",
               bus_a.valid_M, bus_a.aluResult_M, bus_a.zero_M);
    end
    compared++;
    if (bus_a.ready_E !== 1'b1 || bus_a.writeData_M !== 64'd7) begin
      mismatched++;
      $display("[TB] FAIL add_ready_wd: got rdy=%b wd=%h expected 1/7",
               bus_a.ready_E, bus_a.writeData_M);
    end
    tick();
    compared++;
    if (bus_a.valid_M !== 1'b0 || bus_a.aluResult_M !== 64'd12) begin
      mismatched++;
      $display("[TB] FAIL add_hold: got v=%b alu=%h expected 0/c",
               bus_a.valid_M, bus_a.aluResult_M);
    end
  endtask

  // Back-to-back ALU ops, one accepted on every edge
  task automatic test_alu_ops();
    logic [3:0]  ctl [8];
    logic        src [8];
    logic [63:0] rd1 [8];
    logic [63:0] rd2 [8];
    logic [63:0] imm [8];
    logic [63:0] expv[8];
    ctl[0] = 4'b0110; src[0] = 1'b0; rd1[0] = 64'h1234; rd2[0] = 64'h1234; imm[0] = 64'h0;  expv[0] = 64'h0;
    ctl[1] = 4'b0000; src[1] = 1'b1; rd1[1] = 64'hFF;   rd2[1] = 64'h0F;   imm[1] = 64'hF0; expv[1] = 64'hF0;
    ctl[2] = 4'b1111; src[2] = 1'b0; rd1[2] = 64'd5;    rd2[2] = 64'd7;    imm[2] = 64'h0;  expv[2] = 64'h0;
    ctl[3] = 4'b0001; src[3] = 1'b0; rd1[3] = 64'hF0;   rd2[3] = 64'h0F;   imm[3] = 64'h0;  expv[3] = 64'hFF;
    ctl[4] = 4'b1100; src[4] = 1'b0; rd1[4] = 64'h0;    rd2[4] = 64'h0;    imm[4] = 64'h3;  expv[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    ctl[5] = 4'b0111; src[5] = 1'b1; rd1[5] = 64'h1;    rd2[5] = 64'h2;    imm[5] = 64'h55; expv[5] = 64'h55;
    ctl[6] = 4'b0110; src[6] = 1'b0; rd1[6] = 64'd5;    rd2[6] = 64'd7;    imm[6] = 64'h0;  expv[6] = 64'hFFFF_FFFF_FFFF_FFFE;
    ctl[7] = 4'b0010; src[7] = 1'b1; rd1[7] = 64'hFFFF_FFFF_FFFF_FFFF; rd2[7] = 64'h9; imm[7] = 64'h1; expv[7] = 64'h0;
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b0, ctl[i], src[i], 1'b0, 64'h0, imm[i], rd1[i], rd2[i]);
      tick();
      compared++;
      if (bus_a.valid_M !== 1'b1 || bus_a.aluResult_M !== expv[i]) begin
        mismatched++;
        $display("[TB] FAIL alu_op%0d: got v=%b alu=%h expected 1/%h",
                 i, bus_a.valid_M, bus_a.aluResult_M, expv[i]);
      end
      compared++;
      if (bus_a.zero_M !== (expv[i] == 64'h0) || bus_a.writeData_M !== rd2[i]) begin
        mismatched++;
        $display("[TB] FAIL alu_op%0d_zero_wd: got z=%b wd=%h expected %b/%h",
                 i, bus_a.zero_M, bus_a.writeData_M, (expv[i] == 64'h0), rd2[i]);
      end
    end
    bus_a.valid_E = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    logic [63:0] pc  [4];
    logic [63:0] imm [4];
    logic [63:0] rd1 [4];
    logic        bs  [4];
    logic [63:0] expv[4];
    pc[0] = 64'h1000; imm[0] = 64'h4; rd1[0] = 64'h0; bs[0] = 1'b0; expv[0] = 64'h1010;
    pc[1] = 64'h1000; imm[1] = 64'h4; rd1[1] = 64'hDEAD; bs[1] = 1'b1; expv[1] = 64'hDEAD;
    pc[2] = 64'hFFFF_FFFF_FFFF_FFFC; imm[2] = 64'h1; rd1[2] = 64'h0; bs[2] = 1'b0; expv[2] = 64'h0;
    pc[3] = 64'h0; imm[3] = 64'hC000_0000_0000_0001; rd1[3] = 64'h0; bs[3] = 1'b0; expv[3] = 64'h4;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 4'b0010, 1'b0, bs[i], pc[i], imm[i], rd1[i], 64'h0);
      tick();
      compared++;
      if (bus_a.PCBranch_M !== expv[i]) begin
        mismatched++;
        $display("[TB] FAIL branch%0d: got %h expected %h", i, bus_a.PCBranch_M, expv[i]);
      end
    end
    bus_a.valid_E = 1'b0;
    tick();
  endtask

  task automatic test_mul64();
    int edges;
    int ready_low;
    bit found;
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 64'h500, 64'h0, 64'h1, 64'h1);
    tick();
    drive_a(1'b1, 4'b0000, 1'b0, 1'b0, 64'h2000, 64'h1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    // Mid-busy op that must be ignored
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 64'h9999, 64'h0, 64'd1, 64'd1);
    edges     = 1;
    ready_low = 0;
    compared++;
    if (bus_a.ready_E !== 1'b0 || bus_a.valid_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mul64_accept: got rdy=%b v=%b expected 0/0", bus_a.ready_E, bus_a.valid_M);
    end else begin
      ready_low = 1;
    end
    compared++;
    if (bus_a.PCBranch_M !== 64'h500 || bus_a.aluResult_M !== 64'h2) begin
      mismatched++;
      $display("[TB] FAIL mul64_hold_during_busy: got pc=%h alu=%h expected 500/2",
               bus_a.PCBranch_M, bus_a.aluResult_M);
    end
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      edges++;
      if (bus_a.valid_M === 1'b1) found = 1'b1;
      else if (bus_a.ready_E === 1'b0) ready_low++;
    end
    bus_a.valid_E = 1'b0;
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL mul64_timeout: got no valid_M within %0d edges expected 65", edges);
    end else begin
      compared++;
      if (edges != 65 || ready_low != 64) begin
        mismatched++;
        $display("[TB] FAIL mul64_latency: got edges=%0d ready_low=%0d expected 65/64", edges, ready_low);
      end
      compared++;
      if (bus_a.aluResult_M !== 64'hFFFF_FFFF_FFFF_FFFA || bus_a.zero_M !== 1'b0 || bus_a.ready_E !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL mul64_result: got alu=%h z=%b rdy=%b expected fffffffffffffffa/0/1",
                 bus_a.aluResult_M, bus_a.zero_M, bus_a.ready_E);
      end
      compared++;
      if (bus_a.PCBranch_M !== 64'h2004 || bus_a.writeData_M !== 64'hFFFF_FFFF_FFFF_FFFE) begin
        mismatched++;
        $display("[TB] FAIL mul64_pc_wd: got pc=%h wd=%h expected 2004/fffffffffffffffe",
                 bus_a.PCBranch_M, bus_a.writeData_M);
      end
    end
    tick();
    compared++;
    if (bus_a.valid_M !== 1'b0 || bus_a.aluResult_M !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      mismatched++;
      $display("[TB] FAIL mul64_strobe_one_cycle: got v=%b alu=%h expected 0/fffffffffffffffa",
               bus_a.valid_M, bus_a.aluResult_M);
    end
  endtask

  task automatic test_reset_mid_mul();
    int strays;
    drive_a(1'b1, 4'b0000, 1'b0, 1'b0, 64'h40, 64'h1, 64'd3, 64'd5);
    tick();
    bus_a.valid_E = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 64'h0, 64'h0, 64'd1, 64'd1);
    tick();
    compared++;
    if (bus_a.ready_E !== 1'b1 || bus_a.valid_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_ctrl: got rdy=%b v=%b expected 1/0", bus_a.ready_E, bus_a.valid_M);
    end
    compared++;
    if (bus_a.aluResult_M !== 64'd0 || bus_a.PCBranch_M !== 64'd0 ||
        bus_a.writeData_M !== 64'd0 || bus_a.zero_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got alu=%h pc=%h wd=%h z=%b expected all 0",
               bus_a.aluResult_M, bus_a.PCBranch_M, bus_a.writeData_M, bus_a.zero_M);
    end
    reset = 1'b0;
    tick();
    bus_a.valid_E = 1'b0;
    compared++;
    if (bus_a.valid_M !== 1'b1 || bus_a.aluResult_M !== 64'd2) begin
      mismatched++;
      $display("[TB] FAIL midreset_add: got v=%b alu=%h expected 1/2", bus_a.valid_M, bus_a.aluResult_M);
    end
    strays = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus_a.valid_M === 1'b1) strays++;
    end
    compared++;
    if (strays != 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_no_stray: got %0d strobes expected 0", strays);
    end
  endtask

  task automatic test_mul32_back_to_back();
    int edges;
    bit found;
    bus_b.valid_E     = 1'b1;
    bus_b.MulOp_E     = 1'b1;
    bus_b.AluSrc      = 1'b0;
    bus_b.AluControl  = 4'b0000;
    bus_b.BranchSrc_E = 1'b0;
    bus_b.PC_E        = 32'h0;
    bus_b.signImm_E   = 32'h0;
    bus_b.readData1_E = 32'hFFFF;
    bus_b.readData2_E = 32'hFFFF;
    tick();
    bus_b.valid_E = 1'b0;
    edges = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      edges++;
      if (bus_b.valid_M === 1'b1) found = 1'b1;
    end
    compared++;
    if (!found || edges != 9 || bus_b.aluResult_M !== 32'hFFFE0001 ||
        bus_b.zero_M !== 1'b0 || bus_b.ready_E !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mul32_ffff: got edges=%0d alu=%h z=%b rdy=%b expected 9/fffe0001/0/1",
               edges, bus_b.aluResult_M, bus_b.zero_M, bus_b.ready_E);
    end
    // Next MUL presented in the same cycle ready_E returns high
    bus_b.valid_E     = 1'b1;
    bus_b.readData1_E = 32'h0;
    bus_b.readData2_E = 32'h7;
    tick();
    bus_b.valid_E = 1'b0;
    compared++;
    if (bus_b.ready_E !== 1'b0 || bus_b.valid_M !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mul32_second_accept: got rdy=%b v=%b expected 0/0", bus_b.ready_E, bus_b.valid_M);
    end
    edges = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      edges++;
      if (bus_b.valid_M === 1'b1) found = 1'b1;
    end
    compared++;
    if (!found || edges != 9 || bus_b.aluResult_M !== 32'h0 || bus_b.zero_M !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mul32_zero: got edges=%0d alu=%h z=%b expected 9/0/1",
               edges, bus_b.aluResult_M, bus_b.zero_M);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus_a.valid_E     = 1'b0;
    bus_a.MulOp_E     = 1'b0;
    bus_a.AluSrc      = 1'b0;
    bus_a.AluControl  = 4'b0000;
    bus_a.BranchSrc_E = 1'b0;
    bus_a.PC_E        = '0;
    bus_a.signImm_E   = '0;
    bus_a.readData1_E = '0;
    bus_a.readData2_E = '0;
    bus_b.valid_E     = 1'b0;
    bus_b.MulOp_E     = 1'b0;
    bus_b.AluSrc      = 1'b0;
    bus_b.AluControl  = 4'b0000;
    bus_b.BranchSrc_E = 1'b0;
    bus_b.PC_E        = '0;
    bus_b.signImm_E   = '0;
    bus_b.readData1_E = '0;
    bus_b.readData2_E = '0;
    test_reset();
    test_alu_add();
    test_alu_ops();
    test_branch();
    test_mul64();
    test_reset_mid_mul();
    test_mul32_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
